// File: rtl/tile_spawner_pkg.sv
// Shared game definitions: cell geometry, tile exponents and spawner FSM states.
package tile_spawner_pkg;

  localparam int unsigned CELL_W  = 4;
  localparam int unsigned BOARD_N = 16;

  // Tile exponents stored in a cell (0 = empty, 1 = tile 2, 2 = tile 4)
  localparam int unsigned EXP_EMPTY = 0;
  localparam int unsigned EXP_TWO   = 1;
  localparam int unsigned EXP_FOUR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_CHECK,
    ST_SCAN,
    ST_VAL,
    ST_WRITE,
    ST_DONE
  } spawn_state_e;

  // Cell index as used on the board bus: k = row*4 + col
  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/tile_spawner_empty_scan.sv
// Combinational occupancy view of the 4x4 board: per-cell empty flags and a
// board-full indication (no cell empty).
module empty_scan #(
  parameter int unsigned CELL_W = tile_spawner_pkg::CELL_W
) (
  input  logic [tile_spawner_pkg::BOARD_N*CELL_W-1:0] i_board,
  output logic [tile_spawner_pkg::BOARD_N-1:0]        o_cell_empty,
  output logic                                        o_board_full
);
  import tile_spawner_pkg::*;

  // Per-cell empty test and NOR-reduce of the empty flags into board_full
  always_comb begin
    o_cell_empty = '0;
    for (int unsigned k = 0; k < BOARD_N; k++) begin
      o_cell_empty[k] = (i_board[k*CELL_W +: CELL_W] == CELL_W'(EXP_EMPTY));
    end
    o_board_full = ~|o_cell_empty;
  end

endmodule

// File: rtl/tile_spawner.sv
// Places one new tile on an empty cell of the 4x4 board per request.
// Random row/column picks (MAX_TRIES attempts) fall back to a linear scan,
// so every request completes in bounded time.
// Optional feature macro: SPAWN_FOUR_EN (25% chance of a four-tile).
module tile_spawner #(
  parameter int unsigned MAX_TRIES = 4,
  parameter int unsigned CELL_W    = tile_spawner_pkg::CELL_W
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [1:0]                                  rand2b,
  input  logic [tile_spawner_pkg::BOARD_N*CELL_W-1:0] board,
  input  logic                                        spawn_req,
  output logic                                        busy,
  output logic                                        wr_en,
  output logic [3:0]                                  wr_addr,
  output logic [CELL_W-1:0]                           wr_val,
  output logic                                        spawn_done,
  output logic                                        spawn_fail
);
  import tile_spawner_pkg::*;

  localparam logic [3:0] LP_MAX_TRIES = 4'(MAX_TRIES);

  spawn_state_e        r_state;
  spawn_state_e        w_state_nxt;
  logic [1:0]          r_row;
  logic [1:0]          r_col;
  logic [3:0]          r_tries;
  logic [3:0]          r_idx;
  logic [CELL_W-1:0]   r_wr_val;
  logic                r_fail;

  logic [BOARD_N-1:0]  w_cell_empty;
  logic                w_board_full;
  logic [3:0]          w_pick;
  logic                w_pick_empty;
  logic                w_idx_empty;
  logic                w_last_try;

  empty_scan #(
    .CELL_W(CELL_W)
  ) u_empty_scan (
    .i_board      (board),
    .o_cell_empty (w_cell_empty),
    .o_board_full (w_board_full)
  );

  // Occupancy lookups for the current random pick and scan index
  always_comb begin
    w_pick       = cell_index(r_row, r_col);
    w_pick_empty = w_cell_empty[w_pick];
    w_idx_empty  = w_cell_empty[r_idx];
    w_last_try   = ((r_tries + 4'd1) == LP_MAX_TRIES);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (spawn_req) w_state_nxt = w_board_full ? ST_DONE : ST_ROW;
      ST_ROW:   w_state_nxt = ST_COL;
      ST_COL:   w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_pick_empty)    w_state_nxt = ST_VAL;
        else if (w_last_try) w_state_nxt = ST_SCAN;
        else                 w_state_nxt = ST_ROW;
      end
      ST_SCAN:  if (w_idx_empty) w_state_nxt = ST_VAL;
      ST_VAL:   w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: pick coordinates, retry counter, scan index, value and fail flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row    <= '0;
      r_col    <= '0;
      r_tries  <= '0;
      r_idx    <= '0;
      r_wr_val <= '0;
      r_fail   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (spawn_req) r_tries <= '0;
          r_fail <= spawn_req & w_board_full;
        end
        ST_ROW: r_row <= rand2b;
        ST_COL: r_col <= rand2b;
        ST_CHECK: begin
          if (!w_pick_empty) begin
            if (w_last_try) r_idx   <= '0;
            else            r_tries <= r_tries + 4'd1;
          end
        end
        ST_SCAN: begin
          if (w_idx_empty) {r_row, r_col} <= r_idx;
          else             r_idx          <= r_idx + 4'd1;
        end
        ST_VAL: begin
`ifdef SPAWN_FOUR_EN
          r_wr_val <= (rand2b == 2'b00) ? CELL_W'(EXP_FOUR) : CELL_W'(EXP_TWO);
`else
          r_wr_val <= CELL_W'(EXP_TWO);
`endif
        end
        ST_DONE: r_fail <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; write bus is zero outside the write strobe
  always_comb begin
    busy       = (r_state != ST_IDLE);
    wr_en      = (r_state == ST_WRITE);
    wr_addr    = wr_en ? w_pick : '0;
    wr_val     = wr_en ? r_wr_val : '0;
    spawn_done = (r_state == ST_DONE);
    spawn_fail = spawn_done & r_fail;
  end

endmodule

// File: tb/tb_tile_spawner.sv
// Randomized + directed bench for tile_spawner with a cycle-level reference
// model derived from the pick/scan timing rules.
module tb_tile_spawner;

  localparam int MAXT = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    rand2b;
  logic [16*CW-1:0] board_i;
  logic          spawn_req;
  logic          busy;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [CW-1:0] wr_val;
  logic          spawn_done;
  logic          spawn_fail;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          g_rnd[64];

  always #5 clk = ~clk;

  tile_spawner #(
    .MAX_TRIES(MAXT),
    .CELL_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rand2b     (rand2b),
    .board      (board_i),
    .spawn_req  (spawn_req),
    .busy       (busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_val     (wr_val),
    .spawn_done (spawn_done),
    .spawn_fail (spawn_fail)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_empty(input logic [16*CW-1:0] b, input int k);
    return (b[k*CW +: CW] == '0);
  endfunction

  // Reference: cycle 0 = request seen in IDLE; g_rnd[c] is rand2b during cycle c.
  // Pick attempt starting at cycle t uses row=g_rnd[t], col=g_rnd[t+1]; value at t+3.
  // Scan starting at cycle t reaches cell i at t+i; value one cycle later.
  function automatic void model(input logic [16*CW-1:0] b, output int e_wr, output int e_addr,
                                output int e_val, output int e_done, output bit e_fail);
    int t, vc, nempty;
    bit found;
    nempty = 0;
    for (int k = 0; k < 16; k++) if (is_empty(b, k)) nempty++;
    e_addr = 0; e_val = 0;
    if (nempty == 0) begin
      e_fail = 1'b1; e_wr = -1; e_done = 1;
      return;
    end
    e_fail = 1'b0;
    t = 1; found = 1'b0; vc = 0;
    for (int a = 0; a < MAXT; a++) begin
      if (is_empty(b, g_rnd[t]*4 + g_rnd[t+1])) begin
        e_addr = g_rnd[t]*4 + g_rnd[t+1];
        vc = t + 3; found = 1'b1;
        break;
      end
      t += 3;
    end
    if (!found) begin
      for (int i = 0; i < 16; i++) begin
        if (is_empty(b, i)) begin
          e_addr = i; vc = t + i + 1;
          break;
        end
      end
    end
    e_wr   = vc + 1;
    e_done = vc + 2;
`ifdef SPAWN_FOUR_EN
    e_val = (g_rnd[vc] == 0) ? 2 : 1;
`else
    e_val = 1;
`endif
  endfunction

  task automatic run_spawn(input logic [16*CW-1:0] b, input string tag);
    int e_wr, e_addr, e_val, e_done;
    bit e_fail;
    int n_wr, n_done, o_wr, o_addr, o_val, o_done, o_fail, bad_ctl, overlap;
    model(b, e_wr, e_addr, e_val, e_done, e_fail);
    n_wr = 0; n_done = 0; o_wr = -1; o_addr = -1; o_val = -1;
    o_done = -1; o_fail = -1; bad_ctl = 0; overlap = 0;
    check({tag, "_idle"}, 32'(busy), 32'd0);
    board_i   = b;
    spawn_req = 1'b1;
    rand2b    = 2'(g_rnd[0]);
    for (int c = 1; c <= e_done + 1; c++) begin
      @(posedge clk); #1;
      if (wr_en) begin
        n_wr++; o_wr = c; o_addr = int'(wr_addr); o_val = int'(wr_val);
      end
      if (spawn_done) begin
        n_done++; o_done = c; o_fail = int'(spawn_fail);
      end
      if (wr_en && spawn_done) overlap++;
      if (busy !== (c <= e_done)) bad_ctl++;
      if (spawn_fail && !spawn_done) bad_ctl++;
      spawn_req = 1'b0;
      rand2b    = 2'(g_rnd[c]);
    end
    check({tag, "_wr_cnt"}, 32'(n_wr), e_fail ? 32'd0 : 32'd1);
    if (!e_fail) begin
      check({tag, "_wr_cyc"},  32'(o_wr),   32'(e_wr));
      check({tag, "_wr_addr"}, 32'(o_addr), 32'(e_addr));
      check({tag, "_wr_val"},  32'(o_val),  32'(e_val));
    end
    check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
    check({tag, "_done_cyc"}, 32'(o_done), 32'(e_done));
    check({tag, "_fail"},     32'(o_fail), 32'(e_fail));
    check({tag, "_overlap"},  32'(overlap), 32'd0);
    check({tag, "_busy_ctl"}, 32'(bad_ctl), 32'd0);
  endtask

  function automatic logic [16*CW-1:0] one_hole(input int k);
    logic [16*CW-1:0] b;
    b = {16{4'h1}};
    b[k*CW +: CW] = '0;
    return b;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [16*CW-1:0] b;
    int thr;
    rst_n = 1'b0; spawn_req = 1'b0; board_i = '0; rand2b = 2'd0;
    for (int i = 0; i < 64; i++) g_rnd[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({busy, wr_en, wr_addr, wr_val, spawn_done, spawn_fail}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Best case on empty board: row 2, col 1 -> cell 9, value from rand2b=0
    for (int i = 0; i < 64; i++) g_rnd[i] = 3;
    g_rnd[1] = 2; g_rnd[2] = 1; g_rnd[4] = 0;
    run_spawn('0, "best");

    // Only cell 0 empty, picks always land on cell 15 -> scan finds 0
    for (int i = 0; i < 64; i++) g_rnd[i] = 3;
    run_spawn(one_hole(0), "scan0");

    // Full board
    for (int i = 0; i < 64; i++) g_rnd[i] = int'($urandom_range(0, 3));
    run_spawn({16{4'h7}}, "full");

    // Only cell 15 empty: scan walks the whole board
    for (int i = 0; i < 64; i++) g_rnd[i] = i % 2;
    run_spawn(one_hole(15), "scan15");

    // Reset asserted during COL
    for (int i = 0; i < 64; i++) g_rnd[i] = int'($urandom_range(0, 3));
    board_i = '0; spawn_req = 1'b1; rand2b = 2'(g_rnd[0]);
    @(posedge clk); #1;
    check("rst_row_busy", 32'(busy), 32'd1);
    spawn_req = 1'b0; rand2b = 2'(g_rnd[1]);
    @(posedge clk); #1;
    check("rst_col_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", 32'({busy, wr_en, wr_addr, wr_val, spawn_done, spawn_fail}), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("rst_hold_outs", 32'({busy, wr_en, wr_addr, wr_val, spawn_done, spawn_fail}), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) g_rnd[i] = int'($urandom_range(0, 3));
    run_spawn('0, "after_rst");

    // Request held high: back-to-back 7-cycle spawns on an empty board
    board_i = '0; spawn_req = 1'b1; rand2b = 2'($urandom_range(0, 3));
    check("held_idle0", 32'(busy), 32'd0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      check("held_wr",   32'(wr_en),      32'(c % 7 == 5));
      check("held_done", 32'(spawn_done), 32'(c % 7 == 6));
      check("held_busy", 32'(busy),       32'(c % 7 != 0));
      rand2b = 2'($urandom_range(0, 3));
      if (c == 20) spawn_req = 1'b0;
    end
    @(posedge clk); #1;
    check("held_end_idle", 32'(busy), 32'd0);

    // Randomized boards of varying density, including occasional full boards
    for (int n = 0; n < 60; n++) begin
      thr = int'($urandom_range(0, 16));
      b = '0;
      for (int k = 0; k < 16; k++) begin
        if (int'($urandom_range(0, 15)) >= thr) b[k*CW +: CW] = 4'($urandom_range(1, 15));
      end
      for (int i = 0; i < 64; i++) g_rnd[i] = int'($urandom_range(0, 3));
      run_spawn(b, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
